// File: rtl/id_fwd_stage_pkg.sv
// Shared decode constants, control-word layout and stall encoding for the ID stage.
package id_fwd_stage_pkg;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;

  localparam int ALU_W = 9;
  localparam logic [ALU_W-1:0] ALU_ADD  = 9'h001;
  localparam logic [ALU_W-1:0] ALU_SUB  = 9'h002;
  localparam logic [ALU_W-1:0] ALU_AND  = 9'h004;
  localparam logic [ALU_W-1:0] ALU_OR   = 9'h008;
  localparam logic [ALU_W-1:0] ALU_XOR  = 9'h010;
  localparam logic [ALU_W-1:0] ALU_SLT  = 9'h020;
  localparam logic [ALU_W-1:0] ALU_SLTU = 9'h040;
  localparam logic [ALU_W-1:0] ALU_SLL  = 9'h080;
  localparam logic [ALU_W-1:0] ALU_LUI  = 9'h100;

  typedef struct packed {
    logic [ALU_W-1:0] alu_op;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic             use_imm;
    logic             sext_imm;
    logic             mem_rd;
    logic             mem_wr;
    logic             link;
    logic [4:0]       shamt;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  typedef enum logic [3:0] {
    BR_NONE, BR_BEQ, BR_BNE, BR_BGEZ, BR_BGTZ, BR_BLEZ, BR_BLTZ, BR_J, BR_JR
  } br_class_t;

  localparam int BR_W = 4;

endpackage

// File: rtl/id_decoder.sv
// Purely combinational instruction decoder: control word, operand usage and branch class.
module id_decoder
  import id_fwd_stage_pkg::*;
(
  input  logic [31:0]       inst,
  output logic [CTRL_W-1:0] ctrl,
  output logic              uses_rs,
  output logic              uses_rt,
  output logic [BR_W-1:0]   br_class
);

  logic [5:0] op, fn;
  logic [4:0] rt, rd;
  logic [ALU_W-1:0] r_op, i_op;
  ctrl_t c;
  br_class_t br;
  logic unused_rs;

  assign op = inst[31:26];
  assign fn = inst[5:0];
  assign rt = inst[20:16];
  assign rd = inst[15:11];
  assign unused_rs = ^inst[25:21];

  always_comb begin
    r_op = '0;
    case (fn)
      FN_ADDU: r_op = ALU_ADD;
      FN_SUBU: r_op = ALU_SUB;
      FN_AND:  r_op = ALU_AND;
      FN_OR:   r_op = ALU_OR;
      FN_XOR:  r_op = ALU_XOR;
      FN_SLT:  r_op = ALU_SLT;
      FN_SLTU: r_op = ALU_SLTU;
      FN_SLL:  r_op = ALU_SLL;
      default: r_op = '0;
    endcase
    i_op = '0;
    case (op)
      OP_ADDIU, OP_LW, OP_SW: i_op = ALU_ADD;
      OP_SLTI:  i_op = ALU_SLT;
      OP_SLTIU: i_op = ALU_SLTU;
      OP_ANDI:  i_op = ALU_AND;
      OP_ORI:   i_op = ALU_OR;
      OP_XORI:  i_op = ALU_XOR;
      OP_LUI:   i_op = ALU_LUI;
      default:  i_op = '0;
    endcase
  end

  always_comb begin
    c       = '0;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    br      = BR_NONE;
    case (op)
      OP_SPECIAL: begin
        if (fn == FN_JR) begin
          br      = BR_JR;
          uses_rs = 1'b1;
        end else if (fn == FN_JALR) begin
          br         = BR_JR;
          uses_rs    = 1'b1;
          c.rf_we    = 1'b1;
          c.rf_waddr = rd;
          c.link     = 1'b1;
        end else if (r_op != '0) begin
          c.alu_op   = r_op;
          c.rf_we    = 1'b1;
          c.rf_waddr = rd;
          c.shamt    = inst[10:6];
          uses_rs    = (fn != FN_SLL);
          uses_rt    = 1'b1;
        end
      end
      OP_REGIMM: begin
        uses_rs = 1'b1;
        if (rt == RT_BGEZ)      br = BR_BGEZ;
        else if (rt == RT_BLTZ) br = BR_BLTZ;
        else                    uses_rs = 1'b0;
      end
      OP_J:  br = BR_J;
      OP_JAL: begin
        br         = BR_J;
        c.rf_we    = 1'b1;
        c.rf_waddr = 5'd31;
        c.link     = 1'b1;
      end
      OP_BEQ:  begin br = BR_BEQ; uses_rs = 1'b1; uses_rt = 1'b1; end
      OP_BNE:  begin br = BR_BNE; uses_rs = 1'b1; uses_rt = 1'b1; end
      OP_BLEZ: begin br = BR_BLEZ; uses_rs = 1'b1; end
      OP_BGTZ: begin br = BR_BGTZ; uses_rs = 1'b1; end
      OP_SW: begin
        c.alu_op   = ALU_ADD;
        c.use_imm  = 1'b1;
        c.sext_imm = 1'b1;
        c.mem_wr   = 1'b1;
        uses_rs    = 1'b1;
        uses_rt    = 1'b1;
      end
      default: begin
        if (i_op != '0) begin
          c.alu_op   = i_op;
          c.use_imm  = 1'b1;
          c.sext_imm = !(op inside {OP_ANDI, OP_ORI, OP_XORI});
          c.rf_we    = 1'b1;
          c.rf_waddr = rt;
          c.mem_rd   = (op == OP_LW);
          uses_rs    = (op != OP_LUI);
        end
      end
    endcase
  end

  assign ctrl     = c;
  assign br_class = br;

endmodule

// File: rtl/id_fwd_stage.sv
// ID pipeline stage: IF/ID register with instruction hold, regfile read with forwarding,
// load-use stall request and branch resolution.
module id_fwd_stage
  import id_fwd_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_FWD = 3,
  parameter int STALL_W = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [STALL_W-1:0]        stall,
  input  logic                      if_valid,
  input  logic [31:0]               if_pc,
  input  logic [31:0]               inst_sram_rdata,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD-1:0]        fwd_ld,
  input  logic [5*NUM_FWD-1:0]      fwd_waddr,
  input  logic [DATA_W*NUM_FWD-1:0] fwd_wdata,
  input  logic                      wb_we,
  input  logic [4:0]                wb_waddr,
  input  logic [DATA_W-1:0]         wb_wdata,
  output logic                      id_valid,
  output logic [31:0]               id_pc,
  output logic [31:0]               id_inst,
  output logic [DATA_W-1:0]         id_data1,
  output logic [DATA_W-1:0]         id_data2,
  output logic [CTRL_W-1:0]         id_ctrl,
  output logic                      stallreq,
  output logic                      br_e,
  output logic [31:0]               br_addr
);

  logic valid, hold_vld, bubble;
  logic [31:0] pc, hold_inst, inst;
  logic [DATA_W-1:0] rf [32];
  logic [DATA_W-1:0] rf_rs, rf_rt;
  logic [DATA_W:0] sel1, sel2;
  logic [CTRL_W-1:0] ctrl;
  logic uses_rs, uses_rt;
  logic [BR_W-1:0] br_cls;
  logic taken;
  logic [31:0] pc4, target;
  logic unused_stall;

  assign bubble = (stall[1] == STOP) && (stall[2] == NOSTOP);
  assign unused_stall = ^{stall[0], stall[STALL_W-1:3]};

  // IF/ID boundary
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      pc    <= '0;
    end else if (flush || bubble) begin
      valid <= 1'b0;
      pc    <= '0;
    end else if (stall[1] == NOSTOP) begin
      valid <= if_valid;
      pc    <= if_pc;
    end
  end

  // The SRAM returns data for the registered pc only once, so keep it across a full stall.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_vld  <= 1'b0;
      hold_inst <= '0;
    end else if (flush || bubble || stall[1] == NOSTOP) begin
      hold_vld <= 1'b0;
    end else if (valid && !hold_vld && stall[2] == STOP) begin
      hold_vld  <= 1'b1;
      hold_inst <= inst_sram_rdata;
    end
  end

  assign inst = hold_vld ? hold_inst : inst_sram_rdata;

  always_ff @(posedge clk) begin
    if (wb_we && wb_waddr != 5'd0) rf[wb_waddr] <= wb_wdata;
  end

  assign rf_rs = (inst[25:21] == 5'd0) ? '0 : rf[inst[25:21]];
  assign rf_rt = (inst[20:16] == 5'd0) ? '0 : rf[inst[20:16]];

  // Returns {load_pending, data}; later assignments override, so the loop runs oldest first.
  function automatic logic [DATA_W:0] pick(
    input logic [4:0]                addr,
    input logic [NUM_FWD-1:0]        we,
    input logic [NUM_FWD-1:0]        ld,
    input logic [5*NUM_FWD-1:0]      wa,
    input logic [DATA_W*NUM_FWD-1:0] wd,
    input logic                      wbwe,
    input logic [4:0]                wbwa,
    input logic [DATA_W-1:0]         wbwd,
    input logic [DATA_W-1:0]         rfv
  );
    logic [DATA_W:0] r;
    r = {1'b0, rfv};
    if (wbwe && wbwa == addr) r = {1'b0, wbwd};
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (we[i] && wa[5*i +: 5] == addr) r = {ld[i], wd[DATA_W*i +: DATA_W]};
    end
    if (addr == 5'd0) r = '0;
    return r;
  endfunction

  assign sel1 = pick(inst[25:21], fwd_we, fwd_ld, fwd_waddr, fwd_wdata,
                     wb_we, wb_waddr, wb_wdata, rf_rs);
  assign sel2 = pick(inst[20:16], fwd_we, fwd_ld, fwd_waddr, fwd_wdata,
                     wb_we, wb_waddr, wb_wdata, rf_rt);

  id_decoder u_dec (
    .inst     (inst),
    .ctrl     (ctrl),
    .uses_rs  (uses_rs),
    .uses_rt  (uses_rt),
    .br_class (br_cls)
  );

  assign stallreq = valid && ((uses_rs && sel1[DATA_W]) || (uses_rt && sel2[DATA_W]));

  always_comb begin
    pc4    = pc + 32'd4;
    target = pc4 + {{14{inst[15]}}, inst[15:0], 2'b00};
    taken  = 1'b0;
    case (br_class_t'(br_cls))
      BR_BEQ:  taken = (sel1[DATA_W-1:0] == sel2[DATA_W-1:0]);
      BR_BNE:  taken = (sel1[DATA_W-1:0] != sel2[DATA_W-1:0]);
      BR_BGEZ: taken = !sel1[DATA_W-1];
      BR_BLTZ: taken = sel1[DATA_W-1];
      BR_BGTZ: taken = !sel1[DATA_W-1] && (sel1[DATA_W-1:0] != '0);
      BR_BLEZ: taken = sel1[DATA_W-1] || (sel1[DATA_W-1:0] == '0);
      BR_J: begin
        taken  = 1'b1;
        target = {pc4[31:28], inst[25:0], 2'b00};
      end
      BR_JR: begin
        taken  = 1'b1;
        target = sel1[31:0];
      end
      default: taken = 1'b0;
    endcase
  end

  assign id_valid = valid;
  assign id_pc    = pc;
  assign id_inst  = inst;
  assign id_data1 = sel1[DATA_W-1:0];
  assign id_data2 = sel2[DATA_W-1:0];
  assign id_ctrl  = (valid && !stallreq) ? ctrl : '0;
  assign br_e     = valid && !stallreq && taken;
  assign br_addr  = br_e ? target : 32'd0;

endmodule

// File: tb/tb_id_fwd_stage.sv
// Directed scoreboard bench for id_fwd_stage: forwarding, load-use, hold, branches, flush/reset.
module tb_id_fwd_stage;
  import id_fwd_stage_pkg::*;

  localparam int DATA_W  = 32;
  localparam int NUM_FWD = 3;
  localparam int STALL_W = 6;

  logic clk, rst, flush;
  logic [STALL_W-1:0] stall;
  logic if_valid;
  logic [31:0] if_pc, inst_sram_rdata;
  logic [NUM_FWD-1:0] fwd_we, fwd_ld;
  logic [5*NUM_FWD-1:0] fwd_waddr;
  logic [DATA_W*NUM_FWD-1:0] fwd_wdata;
  logic wb_we;
  logic [4:0] wb_waddr;
  logic [DATA_W-1:0] wb_wdata;
  logic id_valid;
  logic [31:0] id_pc, id_inst;
  logic [DATA_W-1:0] id_data1, id_data2;
  logic [CTRL_W-1:0] id_ctrl;
  logic stallreq, br_e;
  logic [31:0] br_addr;

  id_fwd_stage #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD), .STALL_W(STALL_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .if_valid(if_valid), .if_pc(if_pc), .inst_sram_rdata(inst_sram_rdata),
    .fwd_we(fwd_we), .fwd_ld(fwd_ld), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .id_data1(id_data1), .id_data2(id_data2), .id_ctrl(id_ctrl),
    .stallreq(stallreq), .br_e(br_e), .br_addr(br_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {S_VALID, S_PC, S_INST, S_D1, S_D2, S_CTRL, S_STREQ, S_BRE, S_BRADDR} sig_e;
  typedef struct { string tag; sig_e sig; logic [31:0] val; } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;

  function automatic logic [31:0] observe(sig_e s);
    case (s)
      S_VALID:  return {31'd0, id_valid};
      S_PC:     return id_pc;
      S_INST:   return id_inst;
      S_D1:     return id_data1;
      S_D2:     return id_data2;
      S_CTRL:   return 32'(id_ctrl);
      S_STREQ:  return {31'd0, stallreq};
      S_BRE:    return {31'd0, br_e};
      S_BRADDR: return br_addr;
      default:  return 'x;
    endcase
  endfunction

  task automatic push_exp(string tag, sig_e s, logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sig = s; e.val = v;
    sbq.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    logic [31:0] o;
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      o = observe(e.sig);
      total++;
      assert (o === e.val) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fwd_clear();
    fwd_we = '0; fwd_ld = '0; fwd_waddr = '0; fwd_wdata = '0;
  endtask

  task automatic set_fwd(int i, logic we, logic ld, logic [4:0] a, logic [31:0] d);
    fwd_we[i] = we;
    fwd_ld[i] = ld;
    fwd_waddr[5*i +: 5] = a;
    fwd_wdata[DATA_W*i +: DATA_W] = d;
  endtask

  task automatic load(logic [31:0] pc, logic [31:0] ins);
    if_valid = 1'b1; if_pc = pc; stall = '0; flush = 1'b0;
    tick();
    inst_sram_rdata = ins;
    if_valid = 1'b0;
  endtask

  function automatic logic [31:0] r_ins(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_ins(logic [5:0] op, logic [25:0] idx);
    return {op, idx};
  endfunction

  function automatic logic [31:0] ctrl_r(logic [ALU_W-1:0] op, logic [4:0] rd);
    ctrl_t c;
    c = '0; c.alu_op = op; c.rf_we = 1'b1; c.rf_waddr = rd;
    return 32'(c);
  endfunction

  function automatic logic [31:0] ctrl_jal();
    ctrl_t c;
    c = '0; c.rf_we = 1'b1; c.rf_waddr = 5'd31; c.link = 1'b1;
    return 32'(c);
  endfunction

  logic [31:0] ins_a, ins_b, ins_x;

  initial begin
    rst = 1'b0; flush = 1'b0; stall = '0;
    if_valid = 1'b1; if_pc = 32'h100;
    inst_sram_rdata = r_ins(5'd2, 5'd2, 5'd3, FN_ADDU);
    fwd_clear();
    set_fwd(0, 1'b1, 1'b1, 5'd2, 32'h0);
    wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;

    // reset holds everything quiet even with a live load-use hazard on the bus
    tick(); tick();
    push_exp("rst_valid", S_VALID, 32'd0);
    push_exp("rst_pc", S_PC, 32'd0);
    push_exp("rst_streq", S_STREQ, 32'd0);
    push_exp("rst_ctrl", S_CTRL, 32'd0);
    push_exp("rst_bre", S_BRE, 32'd0);
    push_exp("rst_braddr", S_BRADDR, 32'd0);
    check();

    rst = 1'b1; if_valid = 1'b0; fwd_clear();
    inst_sram_rdata = j_ins(OP_JAL, 26'h40);
    wb_we = 1'b1; wb_waddr = 5'd8; wb_wdata = 32'h0000_AAAA; tick();
    wb_waddr = 5'd9; wb_wdata = 32'h0000_5555; tick();
    wb_waddr = 5'd6; wb_wdata = 32'h77; tick();
    wb_waddr = 5'd7; wb_wdata = 32'h77; tick();
    wb_waddr = 5'd0; wb_wdata = 32'hFFFF; tick();
    wb_we = 1'b0;
    push_exp("idle_valid", S_VALID, 32'd0);
    push_exp("idle_bre", S_BRE, 32'd0);
    check();

    // regfile read, wb bypass, forward priority
    load(32'h100, r_ins(5'd8, 5'd9, 5'd10, FN_ADDU));
    push_exp("rf_valid", S_VALID, 32'd1);
    push_exp("rf_pc", S_PC, 32'h100);
    push_exp("rf_d1", S_D1, 32'h0000_AAAA);
    push_exp("rf_d2", S_D2, 32'h0000_5555);
    push_exp("rf_ctrl", S_CTRL, ctrl_r(ALU_ADD, 5'd10));
    push_exp("rf_streq", S_STREQ, 32'd0);
    check();
    wb_we = 1'b1; wb_waddr = 5'd9; wb_wdata = 32'h7777;
    push_exp("wb_bypass", S_D2, 32'h7777);
    check();
    set_fwd(2, 1'b1, 1'b0, 5'd9, 32'h2222);
    push_exp("fwd_over_wb", S_D2, 32'h2222);
    check();
    set_fwd(1, 1'b1, 1'b0, 5'd9, 32'h1111);
    push_exp("fwd_low_idx", S_D2, 32'h1111);
    check();
    wb_we = 1'b0; fwd_clear();

    // youngest source wins; r0 never forwarded
    load(32'h104, r_ins(5'd1, 5'd0, 5'd4, FN_ADDU));
    set_fwd(0, 1'b1, 1'b0, 5'd1, 32'd5);
    set_fwd(1, 1'b1, 1'b0, 5'd1, 32'd9);
    set_fwd(2, 1'b1, 1'b0, 5'd0, 32'hFF);
    push_exp("fwd_ex_d1", S_D1, 32'd5);
    push_exp("fwd_r0_d2", S_D2, 32'd0);
    push_exp("fwd_ctrl", S_CTRL, ctrl_r(ALU_ADD, 5'd4));
    check();
    fwd_clear();

    // load-use
    load(32'h108, r_ins(5'd2, 5'd2, 5'd3, FN_ADDU));
    set_fwd(0, 1'b1, 1'b1, 5'd2, 32'hBAD);
    push_exp("lu_streq", S_STREQ, 32'd1);
    push_exp("lu_ctrl", S_CTRL, 32'd0);
    push_exp("lu_valid", S_VALID, 32'd1);
    check();
    stall = 6'b000111;
    tick();
    inst_sram_rdata = 32'hDEAD_BEEF;
    fwd_clear();
    set_fwd(1, 1'b1, 1'b0, 5'd2, 32'h1234);
    push_exp("lu2_streq", S_STREQ, 32'd0);
    push_exp("lu2_d1", S_D1, 32'h1234);
    push_exp("lu2_d2", S_D2, 32'h1234);
    push_exp("lu2_inst", S_INST, r_ins(5'd2, 5'd2, 5'd3, FN_ADDU));
    push_exp("lu2_pc", S_PC, 32'h108);
    push_exp("lu2_ctrl", S_CTRL, ctrl_r(ALU_ADD, 5'd3));
    check();
    fwd_clear();

    // instruction hold across a three-cycle stall
    ins_a = i_ins(OP_ORI, 5'd0, 5'd11, 16'h55);
    ins_b = r_ins(5'd8, 5'd9, 5'd12, FN_ADDU);
    load(32'h200, ins_a);
    stall = 6'b000110;
    for (int k = 0; k < 3; k++) begin
      tick();
      inst_sram_rdata = 32'h1000_0000 + 32'(k);
      push_exp("hold_inst", S_INST, ins_a);
      push_exp("hold_pc", S_PC, 32'h200);
      push_exp("hold_valid", S_VALID, 32'd1);
      check();
    end
    load(32'h204, ins_b);
    push_exp("rel_inst", S_INST, ins_b);
    push_exp("rel_pc", S_PC, 32'h204);
    push_exp("rel_d1", S_D1, 32'h0000_AAAA);
    check();
    inst_sram_rdata = j_ins(OP_J, 26'h10);
    stall = 6'b000010;
    tick();
    push_exp("bubble_valid", S_VALID, 32'd0);
    push_exp("bubble_bre", S_BRE, 32'd0);
    check();

    // branches
    load(32'h300, i_ins(OP_REGIMM, 5'd5, RT_BGEZ, 16'h0010));
    set_fwd(0, 1'b1, 1'b0, 5'd5, 32'h8000_0000);
    push_exp("bgez_neg_bre", S_BRE, 32'd0);
    push_exp("bgez_neg_addr", S_BRADDR, 32'd0);
    check();
    set_fwd(0, 1'b1, 1'b0, 5'd5, 32'd0);
    push_exp("bgez_zero_bre", S_BRE, 32'd1);
    push_exp("bgez_zero_addr", S_BRADDR, 32'h344);
    check();
    fwd_clear();
    load(32'h400, i_ins(OP_BEQ, 5'd6, 5'd7, 16'hFFFE));
    push_exp("beq_bre", S_BRE, 32'd1);
    push_exp("beq_addr", S_BRADDR, 32'h3FC);
    check();
    set_fwd(0, 1'b1, 1'b0, 5'd7, 32'h78);
    push_exp("beq_ne_bre", S_BRE, 32'd0);
    check();
    fwd_clear();
    load(32'h4000_0010, j_ins(OP_J, 26'h123));
    push_exp("j_bre", S_BRE, 32'd1);
    push_exp("j_addr", S_BRADDR, 32'h4000_048C);
    check();
    load(32'h500, r_ins(5'd8, 5'd0, 5'd0, FN_JR));
    push_exp("jr_addr", S_BRADDR, 32'h0000_AAAA);
    check();
    set_fwd(0, 1'b1, 1'b1, 5'd8, 32'd0);
    push_exp("jr_lu_streq", S_STREQ, 32'd1);
    push_exp("jr_lu_bre", S_BRE, 32'd0);
    push_exp("jr_lu_addr", S_BRADDR, 32'd0);
    check();
    fwd_clear();
    load(32'h600, j_ins(OP_JAL, 26'h40));
    push_exp("jal_addr", S_BRADDR, 32'h100);
    push_exp("jal_ctrl", S_CTRL, ctrl_jal());
    check();

    // flush while stalled clears the slot and the held instruction
    load(32'h700, r_ins(5'd8, 5'd9, 5'd10, FN_ADDU));
    stall = 6'b000110;
    tick();
    inst_sram_rdata = 32'h1111_1111;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    push_exp("flush_valid", S_VALID, 32'd0);
    push_exp("flush_bre", S_BRE, 32'd0);
    push_exp("flush_streq", S_STREQ, 32'd0);
    check();
    tick();
    ins_x = 32'h2468_ACE0;
    inst_sram_rdata = ins_x;
    push_exp("flush_nohold", S_INST, ins_x);
    check();

    // reset in the middle of a stall
    load(32'h800, j_ins(OP_JAL, 26'h40));
    stall = 6'b000110;
    tick();
    inst_sram_rdata = 32'h3333_3333;
    set_fwd(0, 1'b1, 1'b1, 5'd8, 32'd0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    ins_x = 32'h1357_9BDF;
    inst_sram_rdata = ins_x;
    push_exp("mrst_valid", S_VALID, 32'd0);
    push_exp("mrst_pc", S_PC, 32'd0);
    push_exp("mrst_bre", S_BRE, 32'd0);
    push_exp("mrst_braddr", S_BRADDR, 32'd0);
    push_exp("mrst_ctrl", S_CTRL, 32'd0);
    push_exp("mrst_streq", S_STREQ, 32'd0);
    push_exp("mrst_nohold", S_INST, ins_x);
    check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
